// File: rtl/de_stage_pkg.sv
// Shared definitions for the RV32I decode stage: opcodes, bus layouts and decode helpers.
// The DE latch field order is also used by the AGEX unpacker.
package de_stage_pkg;

    localparam int DBITS       = 32;
    localparam int INSTBITS    = 32;
    localparam int REGNO       = 32;
    localparam int REGBITS     = 5;
    localparam int SB_CNT_BITS = 2;

    localparam int OPCODE_LSB = 0;
    localparam int RD_LSB     = 7;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [31:0] BUS_CANARY_VALUE = 32'hC0DE_CAFE;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_R    = 3'd1,
        FMT_I    = 3'd2,
        FMT_S    = 3'd3,
        FMT_B    = 3'd4,
        FMT_U    = 3'd5,
        FMT_J    = 3'd6
    } imm_fmt_e;

    typedef struct packed {
        logic [INSTBITS-1:0] inst;
        logic [DBITS-1:0]    pc;
        logic [DBITS-1:0]    pcplus;
        logic [31:0]         inst_count;
        logic [31:0]         canary;
    } fe_latch_t;

    typedef struct packed {
        logic                valid;
        logic [INSTBITS-1:0] inst;
        logic [DBITS-1:0]    pc;
        logic [DBITS-1:0]    pcplus;
        logic [6:0]          op;
        logic [REGBITS-1:0]  rd;
        logic                wr_rd;
        logic [DBITS-1:0]    rs1_val;
        logic [DBITS-1:0]    rs2_val;
        logic [DBITS-1:0]    imm;
        logic [31:0]         inst_count;
    } de_latch_t;

    typedef struct packed {
        logic               wr_en;
        logic [REGBITS-1:0] wr_reg;
        logic [DBITS-1:0]   wr_data;
    } wb_bus_t;

    typedef struct packed {
        logic     uses_rs1;
        logic     uses_rs2;
        logic     wr_rd;
        imm_fmt_e fmt;
    } dec_ctrl_t;

    localparam int FE_latch_WIDTH = $bits(fe_latch_t);
    localparam int DE_latch_WIDTH = $bits(de_latch_t);

    function automatic dec_ctrl_t decode_ctrl(input logic [6:0] opcode);
        dec_ctrl_t c;
        case (opcode)
            OP_LUI:    c = '{1'b0, 1'b0, 1'b1, FMT_U};
            OP_AUIPC:  c = '{1'b0, 1'b0, 1'b1, FMT_U};
            OP_JAL:    c = '{1'b0, 1'b0, 1'b1, FMT_J};
            OP_JALR:   c = '{1'b1, 1'b0, 1'b1, FMT_I};
            OP_BRANCH: c = '{1'b1, 1'b1, 1'b0, FMT_B};
            OP_LOAD:   c = '{1'b1, 1'b0, 1'b1, FMT_I};
            OP_STORE:  c = '{1'b1, 1'b1, 1'b0, FMT_S};
            OP_OPIMM:  c = '{1'b1, 1'b0, 1'b1, FMT_I};
            OP_OP:     c = '{1'b1, 1'b1, 1'b1, FMT_R};
            default:   c = '{1'b0, 1'b0, 1'b0, FMT_NONE};
        endcase
        return c;
    endfunction

    // Opcode bits never feed the immediate, so only inst[31:7] is taken.
    function automatic logic [DBITS-1:0] decode_imm(input logic [INSTBITS-1:7] inst,
                                                    input imm_fmt_e fmt);
        logic [DBITS-1:0] imm;
        case (fmt)
            FMT_I:   imm = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   imm = {inst[31:12], 12'h000};
            FMT_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = {DBITS{1'b0}};
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/de_stage_if.sv
// Bus bundle between the decode stage and its FE / AGEX / WB neighbours.
interface de_stage_if;
    import de_stage_pkg::*;

    fe_latch_t FE_latch_in;
    logic      from_AGEX_to_DE;
    wb_bus_t   from_WB_to_DE;
    de_latch_t DE_latch_out;
    logic      from_DE_to_FE;
    logic      canary_err;

    modport master (
        output FE_latch_in, from_AGEX_to_DE, from_WB_to_DE,
        input  DE_latch_out, from_DE_to_FE, canary_err
    );

    modport slave (
        input  FE_latch_in, from_AGEX_to_DE, from_WB_to_DE,
        output DE_latch_out, from_DE_to_FE, canary_err
    );
endinterface

// File: rtl/de_scoreboard.sv
// Per-register in-flight writer counters; busy lookups already discount a same-cycle write-back.
module de_scoreboard
    import de_stage_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               issue_en,
    input  logic [REGBITS-1:0] issue_rd,
    input  logic               wb_en,
    input  logic [REGBITS-1:0] wb_reg,
    input  logic [REGBITS-1:0] q_rs1,
    input  logic [REGBITS-1:0] q_rs2,
    input  logic [REGBITS-1:0] q_rd,
    output logic               busy_rs1_o,
    output logic               busy_rs2_o,
    output logic               full_rd_o
);
    localparam logic [SB_CNT_BITS-1:0] CNT_MAX = {SB_CNT_BITS{1'b1}};
    localparam logic [SB_CNT_BITS-1:0] CNT_ONE = {{(SB_CNT_BITS-1){1'b0}}, 1'b1};
    localparam logic [SB_CNT_BITS-1:0] CNT_ZERO = {SB_CNT_BITS{1'b0}};

    logic [SB_CNT_BITS-1:0] cnt_q [REGNO];
    logic [SB_CNT_BITS-1:0] cnt_d [REGNO];
    logic [REGNO-1:0]       inc_s;
    logic [REGNO-1:0]       dec_s;
    logic                   wb_rs1_s;
    logic                   wb_rs2_s;

    // Next counter values; a decrement of an empty counter is dropped.
    always_comb begin
        for (int r = 0; r < REGNO; r++) begin
            inc_s[r] = issue_en && (issue_rd == REGBITS'(r)) && (r != 0);
            dec_s[r] = wb_en && (wb_reg == REGBITS'(r)) && (r != 0);
            if (inc_s[r] && !dec_s[r]) begin
                cnt_d[r] = cnt_q[r] + CNT_ONE;
            end else if (dec_s[r] && !inc_s[r] && (cnt_q[r] != CNT_ZERO)) begin
                cnt_d[r] = cnt_q[r] - CNT_ONE;
            end else begin
                cnt_d[r] = cnt_q[r];
            end
        end
    end

    // Counter state register.
    always_ff @(posedge clk) begin
        for (int r = 0; r < REGNO; r++) begin
            if (reset) begin
                cnt_q[r] <= CNT_ZERO;
            end else begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    assign wb_rs1_s   = wb_en && (wb_reg == q_rs1);
    assign wb_rs2_s   = wb_en && (wb_reg == q_rs2);
    assign busy_rs1_o = (q_rs1 != 5'd0) && (cnt_q[q_rs1] > {{(SB_CNT_BITS-1){1'b0}}, wb_rs1_s});
    assign busy_rs2_o = (q_rs2 != 5'd0) && (cnt_q[q_rs2] > {{(SB_CNT_BITS-1){1'b0}}, wb_rs2_s});
    assign full_rd_o  = (q_rd != 5'd0) && (cnt_q[q_rd] == CNT_MAX);

endmodule

// File: rtl/de_stage.sv
// RV32I decode stage: field decode, write-first register file, RAW stall and DE latch.
// Optional bus-canary checking is enabled by defining DE_CANARY_CHECK_EN.
module de_stage
    import de_stage_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    de_stage_if.slave  bus
);
    fe_latch_t          fe_s;
    wb_bus_t            wb_s;
    dec_ctrl_t          ctrl_s;
    de_latch_t          de_latch_d;
    de_latch_t          de_latch_q;
    logic [DBITS-1:0]   rf_q [REGNO];
    logic [REGBITS-1:0] rd_s, rs1_s, rs2_s;
    logic [DBITS-1:0]   rs1_val_s, rs2_val_s, imm_s;
    logic               valid_s, mispred_s, stall_s, issue_s;
    logic               busy_rs1_s, busy_rs2_s, full_rd_s;
    logic               canary_err_s;

    assign fe_s      = bus.FE_latch_in;
    assign wb_s      = bus.from_WB_to_DE;
    assign mispred_s = bus.from_AGEX_to_DE;
    assign valid_s   = (fe_s.inst != 32'd0);
    assign rd_s      = fe_s.inst[RD_LSB +: REGBITS];
    assign rs1_s     = fe_s.inst[RS1_LSB +: REGBITS];
    assign rs2_s     = fe_s.inst[RS2_LSB +: REGBITS];
    assign ctrl_s    = decode_ctrl(fe_s.inst[OPCODE_LSB +: 7]);
    assign imm_s     = decode_imm(fe_s.inst[INSTBITS-1:7], ctrl_s.fmt);

    assign rs1_val_s = (rs1_s == 5'd0) ? {DBITS{1'b0}} :
                       (wb_s.wr_en && (wb_s.wr_reg == rs1_s)) ? wb_s.wr_data : rf_q[rs1_s];
    assign rs2_val_s = (rs2_s == 5'd0) ? {DBITS{1'b0}} :
                       (wb_s.wr_en && (wb_s.wr_reg == rs2_s)) ? wb_s.wr_data : rf_q[rs2_s];

    de_scoreboard u_sb (
        .clk        (clk),
        .reset      (reset),
        .issue_en   (issue_s && ctrl_s.wr_rd),
        .issue_rd   (rd_s),
        .wb_en      (wb_s.wr_en),
        .wb_reg     (wb_s.wr_reg),
        .q_rs1      (rs1_s),
        .q_rs2      (rs2_s),
        .q_rd       (rd_s),
        .busy_rs1_o (busy_rs1_s),
        .busy_rs2_o (busy_rs2_s),
        .full_rd_o  (full_rd_s)
    );

    // Stall is combinational so FE freezes in the same cycle the hazard is seen.
    assign stall_s = !reset && valid_s && !mispred_s &&
                     ((ctrl_s.uses_rs1 && busy_rs1_s) ||
                      (ctrl_s.uses_rs2 && busy_rs2_s) ||
                      (ctrl_s.wr_rd && full_rd_s));
    assign issue_s = valid_s && !mispred_s && !stall_s;

    // Next DE latch contents: decoded instruction on issue, otherwise a bubble.
    always_comb begin
        de_latch_d = de_latch_t'({DE_latch_WIDTH{1'b0}});
        if (issue_s) begin
            de_latch_d.valid      = 1'b1;
            de_latch_d.inst       = fe_s.inst;
            de_latch_d.pc         = fe_s.pc;
            de_latch_d.pcplus     = fe_s.pcplus;
            de_latch_d.op         = fe_s.inst[OPCODE_LSB +: 7];
            de_latch_d.rd         = rd_s;
            de_latch_d.wr_rd      = ctrl_s.wr_rd;
            de_latch_d.rs1_val    = rs1_val_s;
            de_latch_d.rs2_val    = rs2_val_s;
            de_latch_d.imm        = imm_s;
            de_latch_d.inst_count = fe_s.inst_count;
        end else begin
            de_latch_d = de_latch_t'({DE_latch_WIDTH{1'b0}});
        end
    end

    // DE pipeline latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            de_latch_q <= de_latch_t'({DE_latch_WIDTH{1'b0}});
        end else begin
            de_latch_q <= de_latch_d;
        end
    end

    // Register file; x0 is never written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < REGNO; r++) begin
                rf_q[r] <= {DBITS{1'b0}};
            end
        end else if (wb_s.wr_en && (wb_s.wr_reg != 5'd0)) begin
            rf_q[wb_s.wr_reg] <= wb_s.wr_data;
        end
    end

`ifdef DE_CANARY_CHECK_EN
    logic canary_err_q;

    // Sticky canary mismatch on any real, non-squashed instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            canary_err_q <= 1'b0;
        end else if (valid_s && !mispred_s && (fe_s.canary != BUS_CANARY_VALUE)) begin
            canary_err_q <= 1'b1;
        end
    end

    assign canary_err_s = canary_err_q;
`else
    logic [31:0] unused_canary_s;
    assign unused_canary_s = fe_s.canary;
    assign canary_err_s    = 1'b0;
`endif

    assign bus.DE_latch_out  = de_latch_q;
    assign bus.from_DE_to_FE = stall_s;
    assign bus.canary_err    = canary_err_s;

endmodule

// File: tb/tb_de_stage.sv
// Table-driven bench for de_stage: one row per cycle, plus reset-during-stall and canary sequences.
module tb_de_stage;
    import de_stage_pkg::*;

    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;

    typedef struct {
        logic [31:0] inst;
        logic        wb_en;
        logic [4:0]  wb_reg;
        logic [31:0] wb_data;
        logic        mis;
        logic        e_stall;
        logic        e_valid;
        logic [4:0]  e_rd;
        logic        e_wr;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        logic [31:0] e_imm;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[$];

    de_stage_if bus();

    de_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] inst, input logic [31:0] canary, input logic mis,
                         input logic wen, input logic [4:0] wreg, input logic [31:0] wdata,
                         input logic [31:0] pc);
        bus.FE_latch_in.inst       = inst;
        bus.FE_latch_in.pc         = pc;
        bus.FE_latch_in.pcplus     = pc + 32'd4;
        bus.FE_latch_in.inst_count = pc >> 2;
        bus.FE_latch_in.canary     = canary;
        bus.from_AGEX_to_DE        = mis;
        bus.from_WB_to_DE.wr_en    = wen;
        bus.from_WB_to_DE.wr_reg   = wreg;
        bus.from_WB_to_DE.wr_data  = wdata;
    endtask

    function automatic logic [31:0] latch_nonzero();
        return {31'd0, (bus.DE_latch_out != de_latch_t'({DE_latch_WIDTH{1'b0}}))};
    endfunction

    function automatic vec_t mk(input logic [31:0] inst, input logic wb_en, input logic [4:0] wb_reg,
                                input logic [31:0] wb_data, input logic mis, input logic e_stall,
                                input logic e_valid, input logic [4:0] e_rd, input logic e_wr,
                                input logic [31:0] e_rs1, input logic [31:0] e_rs2,
                                input logic [31:0] e_imm);
        vec_t v;
        v = '{inst, wb_en, wb_reg, wb_data, mis, e_stall, e_valid, e_rd, e_wr, e_rs1, e_rs2, e_imm};
        return v;
    endfunction

    initial begin
        logic exp_err;
`ifdef DE_CANARY_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        //            inst          wb reg   data          mis stl val rd    wr rs1           rs2           imm
        vecs.push_back(mk(32'h00000000, N, 5'd0, 32'h0,     N, N, N, 5'd0,  N, 32'h0,        32'h0,        32'h0));
        vecs.push_back(mk(32'h00500093, N, 5'd0, 32'h0,     N, N, Y, 5'd1,  Y, 32'h0,        32'h0,        32'h5));
        vecs.push_back(mk(32'h00700113, N, 5'd0, 32'h0,     N, N, Y, 5'd2,  Y, 32'h0,        32'h0,        32'h7));
        vecs.push_back(mk(32'h00100193, N, 5'd0, 32'h0,     N, N, Y, 5'd3,  Y, 32'h0,        32'h0,        32'h1));
        vecs.push_back(mk(32'h00318233, N, 5'd0, 32'h0,     N, Y, N, 5'd0,  N, 32'h0,        32'h0,        32'h0));
        vecs.push_back(mk(32'h00318233, Y, 5'd1, 32'h5,     N, Y, N, 5'd0,  N, 32'h0,        32'h0,        32'h0));
        vecs.push_back(mk(32'h00318233, Y, 5'd3, 32'h1,     N, N, Y, 5'd4,  Y, 32'h1,        32'h1,        32'h0));
        vecs.push_back(mk(32'h00100193, Y, 5'd4, 32'h2,     N, N, Y, 5'd3,  Y, 32'h0,        32'h5,        32'h1));
        vecs.push_back(mk(32'h00318233, N, 5'd0, 32'h0,     N, Y, N, 5'd0,  N, 32'h0,        32'h0,        32'h0));
        vecs.push_back(mk(32'h00318233, N, 5'd0, 32'h0,     Y, N, N, 5'd0,  N, 32'h0,        32'h0,        32'h0));
        vecs.push_back(mk(32'h00020313, Y, 5'd2, 32'h7,     N, N, Y, 5'd6,  Y, 32'h2,        32'h0,        32'h0));
        vecs.push_back(mk(32'h00000000, Y, 5'd3, 32'h1,     N, N, N, 5'd0,  N, 32'h0,        32'h0,        32'h0));
        vecs.push_back(mk(32'h00100293, N, 5'd0, 32'h0,     N, N, Y, 5'd5,  Y, 32'h0,        32'h5,        32'h1));
        vecs.push_back(mk(32'h00200293, N, 5'd0, 32'h0,     N, N, Y, 5'd5,  Y, 32'h0,        32'h7,        32'h2));
        vecs.push_back(mk(32'h00300293, N, 5'd0, 32'h0,     N, N, Y, 5'd5,  Y, 32'h0,        32'h1,        32'h3));
        vecs.push_back(mk(32'h00400293, N, 5'd0, 32'h0,     N, Y, N, 5'd0,  N, 32'h0,        32'h0,        32'h0));
        vecs.push_back(mk(32'h00400293, Y, 5'd5, 32'h1,     N, Y, N, 5'd0,  N, 32'h0,        32'h0,        32'h0));
        vecs.push_back(mk(32'h00400293, N, 5'd0, 32'h0,     N, N, Y, 5'd5,  Y, 32'h0,        32'h2,        32'h4));
        vecs.push_back(mk(32'h00500293, N, 5'd0, 32'h0,     N, Y, N, 5'd0,  N, 32'h0,        32'h0,        32'h0));
        vecs.push_back(mk(32'h00900013, N, 5'd0, 32'h0,     N, N, Y, 5'd0,  Y, 32'h0,        32'h0,        32'h9));
        vecs.push_back(mk(32'h000003B3, N, 5'd0, 32'h0,     N, N, Y, 5'd7,  Y, 32'h0,        32'h0,        32'h0));
        vecs.push_back(mk(32'h00000433, Y, 5'd0, 32'hFFFF,  N, N, Y, 5'd8,  Y, 32'h0,        32'h0,        32'h0));
        vecs.push_back(mk(32'hFFF00393, N, 5'd0, 32'h0,     N, N, Y, 5'd7,  Y, 32'h0,        32'h0,        32'hFFFFFFFF));
        vecs.push_back(mk(32'hFE112E23, N, 5'd0, 32'h0,     N, N, Y, 5'd28, N, 32'h7,        32'h5,        32'hFFFFFFFC));
        vecs.push_back(mk(32'hFE000CE3, N, 5'd0, 32'h0,     N, N, Y, 5'd25, N, 32'h0,        32'h0,        32'hFFFFFFF8));
        vecs.push_back(mk(32'h12345437, N, 5'd0, 32'h0,     N, N, Y, 5'd8,  Y, 32'h0,        32'h1,        32'h12345000));
        vecs.push_back(mk(32'h008000EF, N, 5'd0, 32'h0,     N, N, Y, 5'd1,  Y, 32'h0,        32'h0,        32'h8));

        // Reset state.
        reset = 1'b1;
        drive(32'h0, BUS_CANARY_VALUE, N, N, 5'd0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("reset.latch_zero", latch_nonzero(), 32'd0);
        check("reset.stall", {31'd0, bus.from_DE_to_FE}, 32'd0);
        check("reset.canary_err", {31'd0, bus.canary_err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            logic [31:0] pc;
            pc = 32'h1000 + 32'(i * 4);
            @(negedge clk);
            drive(vecs[i].inst, BUS_CANARY_VALUE, vecs[i].mis, vecs[i].wb_en, vecs[i].wb_reg,
                  vecs[i].wb_data, pc);
            #1;
            check($sformatf("row%0d.stall", i), {31'd0, bus.from_DE_to_FE}, {31'd0, vecs[i].e_stall});
            @(posedge clk);
            #1;
            if (vecs[i].e_valid) begin
                check($sformatf("row%0d.valid", i), {31'd0, bus.DE_latch_out.valid}, 32'd1);
                check($sformatf("row%0d.inst", i), bus.DE_latch_out.inst, vecs[i].inst);
                check($sformatf("row%0d.pc", i), bus.DE_latch_out.pc, pc);
                check($sformatf("row%0d.inst_count", i), bus.DE_latch_out.inst_count, pc >> 2);
                check($sformatf("row%0d.rd", i), {27'd0, bus.DE_latch_out.rd}, {27'd0, vecs[i].e_rd});
                check($sformatf("row%0d.wr_rd", i), {31'd0, bus.DE_latch_out.wr_rd}, {31'd0, vecs[i].e_wr});
                check($sformatf("row%0d.rs1_val", i), bus.DE_latch_out.rs1_val, vecs[i].e_rs1);
                check($sformatf("row%0d.rs2_val", i), bus.DE_latch_out.rs2_val, vecs[i].e_rs2);
                check($sformatf("row%0d.imm", i), bus.DE_latch_out.imm, vecs[i].e_imm);
            end else begin
                check($sformatf("row%0d.bubble", i), latch_nonzero(), 32'd0);
            end
        end

        // Reset while stalled on x5 (counter full): bubble, no stall, cleared scoreboard and regfile.
        @(negedge clk);
        drive(32'h000284B3, BUS_CANARY_VALUE, N, N, 5'd0, 32'h0, 32'h2000);
        #1;
        check("rst_stall.pre_stall", {31'd0, bus.from_DE_to_FE}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_stall.stall_in_reset", {31'd0, bus.from_DE_to_FE}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_stall.bubble", latch_nonzero(), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_stall.stall_after", {31'd0, bus.from_DE_to_FE}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_stall.valid", {31'd0, bus.DE_latch_out.valid}, 32'd1);
        check("rst_stall.rd", {27'd0, bus.DE_latch_out.rd}, 32'd9);
        check("rst_stall.rs1_val", bus.DE_latch_out.rs1_val, 32'd0);

        // Canary: bubbles and squashed instructions are ignored, a real one is sticky until reset.
        @(negedge clk);
        drive(32'h0, 32'hBAD0_BAD0, N, N, 5'd0, 32'h0, 32'h3000);
        @(posedge clk);
        #1;
        check("canary.bubble", {31'd0, bus.canary_err}, 32'd0);
        @(negedge clk);
        drive(32'h00500093, 32'hBAD0_BAD0, Y, N, 5'd0, 32'h0, 32'h3004);
        @(posedge clk);
        #1;
        check("canary.squashed", {31'd0, bus.canary_err}, 32'd0);
        @(negedge clk);
        drive(32'h00500093, 32'hBAD0_BAD0, N, N, 5'd0, 32'h0, 32'h3008);
        @(posedge clk);
        #1;
        check("canary.set", {31'd0, bus.canary_err}, {31'd0, exp_err});
        @(negedge clk);
        drive(32'h00700113, BUS_CANARY_VALUE, N, N, 5'd0, 32'h0, 32'h300C);
        @(posedge clk);
        #1;
        check("canary.sticky", {31'd0, bus.canary_err}, {31'd0, exp_err});
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("canary.cleared", {31'd0, bus.canary_err}, 32'd0);
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
